ahb_copy_master: RTL and testbench
==================================

Name: ahb_copy_master

Overview:
- Single-channel AHB-lite bus master that copies a block of 32-bit words from a source address to a destination address.
- Sits on the master side of the system AHB-lite bus, the opposite end of the slave-side decoder, mux and peripheral slaves.
- Lets firmware or a test controller move data between flash, SRAM, GPIO and APB-subsystem address ranges without CPU load/store loops.
- Non-pipelined: one outstanding transfer at a time.

Parameters:
LEN_W, 16, width of the word-count input; maximum copy is 2^LEN_W-1 words.

Ports:
HCLK  in  1  system clock; all logic on rising edge.
HRESET  in  1  reset, synchronous, active-high.
start  in  1  command strobe; sampled only in IDLE.
src_addr  in  32  source byte address; bits[1:0] forced to 0 on capture.
dst_addr  in  32  destination byte address; bits[1:0] forced to 0 on capture.
len  in  LEN_W  number of words to copy.
busy  out  1  high while a copy is in progress.
done  out  1  one-cycle pulse at end of copy (normal or aborted).
err  out  1  sticky; set on error response, cleared by next accepted start.
HADDR  out  32  AHB address.
HTRANS  out  2  AHB transfer type; only IDLE (00) or NONSEQ (10) driven.
HWRITE  out  1  AHB write enable.
HSIZE  out  3  constant 3'b010 (word).
HWDATA  out  32  AHB write data.
HRDATA  in  32  AHB read data.
HREADY  in  1  bus ready (muxed HREADYOUT of selected slave).
HRESP  in  1  1 = ERROR response.

Behaviour:
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, err=0. Reset mid-transfer returns to IDLE with HTRANS=00 from the next cycle; no completion and no done pulse.
- All AHB outputs are registered except HSIZE.
- States: IDLE, RD_A, RD_D, WR_A, WR_D, DONE.
- IDLE, start=1, len!=0: capture src, dst and count; clear err; go to RD_A.
- IDLE, start=1, len=0: clear err; go to DONE with no bus traffic.
- start outside IDLE is ignored.
- RD_A: HTRANS=NONSEQ, HWRITE=0, HADDR=src. Held until an edge with HREADY=1, then go to RD_D.
- RD_D: HTRANS=IDLE; HADDR/HWRITE hold. On edge with HREADY=1:
  - HRESP=0: latch HRDATA into buffer, go to WR_A.
  - HRESP=1: discard data, set err, go to DONE.
- WR_A: HTRANS=NONSEQ, HWRITE=1, HADDR=dst. Held until HREADY=1, then go to WR_D. HWDATA is loaded with the buffer on this same edge.
- WR_D: HTRANS=IDLE; HWDATA stable for the whole phase. On edge with HREADY=1:
  - HRESP=1: set err, go to DONE.
  - Otherwise: src+=4, dst+=4 (mod 2^32 wrap), count-=1; if count reaches 0 go to DONE, else go to RD_A.
- Error response (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1): the master already drives IDLE in data phases, so no cancellation is needed. Abort only on the final HREADY=1 cycle. Remaining words are not transferred.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE. A start in DONE is ignored.
- busy=1 in RD_A, RD_D, WR_A and WR_D only.
- Timing with zero waits: 4 cycles per word. With start sampled at edge E0, RD_A occupies the cycle after E0, and done pulses 4*len+1 cycles after E0.

Test Plan:
1. src=0x2000_0000, dst=0x2000_0100, len=1, HREADY=1, slave returns 0xDEADBEEF:
   - Cycle 1: NONSEQ read at 0x2000_0000.
   - Cycle 3: NONSEQ write at 0x2000_0100.
   - Cycle 4: HWDATA=0xDEADBEEF.
   - Cycle 5: done=1, busy=0.
2. len=4, slave inserts 2 wait states in every data phase:
   - HADDR/HTRANS stable through waits.
   - Writes land at dst+0x0, +0x4, +0x8, +0xC with matching data.
   - done at cycle 33.
3. len=0: done=1 in cycle 1, busy never high, HTRANS=00 throughout.
4. len=3, two-cycle ERROR on the second read:
   - err=1 and done pulse one cycle after the error completes.
   - Exactly one write (dst+0); nothing written to dst+4.
   - Next start clears err.
5. src=0xFFFF_FFFC, dst=0x0000_1000, len=2: second read at 0x0000_0000. src_addr=0x2000_0003 is read at 0x2000_0000.
6. Stimulus:
   - start pulsed while busy: no effect on count or addresses.
   - HRESET=1 during WR_A: next cycle HTRANS=00, busy=0, no done pulse.
   - New start afterwards: copy runs normally.

Source files
------------

// File: rtl/ahb_copy_master.sv
// ahb_copy_master
//   Single-channel AHB-lite block-copy master. It copies len 32-bit words
//   from src_addr to dst_addr, one word at a time: a read (address phase,
//   then data phase) followed by a write (address phase, then data phase).
//   Only one transfer is outstanding at any time, and the master drives
//   HTRANS=IDLE during every data phase. An ERROR response aborts the copy.
//
// Ports
//   HCLK, HRESET        clock, synchronous active-high reset
//   start               command strobe, sampled only while idle
//   src_addr, dst_addr  byte addresses, word aligned on capture
//   len                 word count (0 gives an immediate done pulse)
//   busy                high while a copy is moving data
//   done                one-cycle pulse when a copy ends (normal or aborted)
//   err                 sticky error flag, cleared by the next accepted start
//   HADDR..HWDATA       registered AHB-lite master outputs (HSIZE constant)
//   HRDATA, HREADY,     AHB-lite slave-side response inputs
//   HRESP
module ahb_copy_master #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_D,
    S_WR_A,
    S_WR_D,
    S_DONE
  } state_t;

  state_t           state;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] cnt_q;
  logic [31:0]      buf_q;

  assign HSIZE = 3'b010;

  // Bus outputs are loaded on the edge that enters the state they belong to,
  // so every AHB output (except HSIZE) comes straight from a flop.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= S_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      buf_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      HADDR  <= '0;
      HTRANS <= HTRANS_IDLE;
      HWRITE <= 1'b0;
      HWDATA <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err <= 1'b0;
            if (len != '0) begin
              src_q  <= src_addr & WORD_MASK;
              dst_q  <= dst_addr & WORD_MASK;
              cnt_q  <= len;
              HADDR  <= src_addr & WORD_MASK;
              HTRANS <= HTRANS_NONSEQ;
              HWRITE <= 1'b0;
              busy   <= 1'b1;
              state  <= S_RD_A;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_RD_A: begin
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            state  <= S_RD_D;
          end
        end

        S_RD_D: begin
          if (HREADY) begin
            if (HRESP) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              buf_q  <= HRDATA;
              HADDR  <= dst_q;
              HTRANS <= HTRANS_NONSEQ;
              HWRITE <= 1'b1;
              state  <= S_WR_A;
            end
          end
        end

        S_WR_A: begin
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            HWDATA <= buf_q;
            state  <= S_WR_D;
          end
        end

        S_WR_D: begin
          if (HREADY) begin
            if (HRESP) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              src_q <= src_q + 32'd4;
              dst_q <= dst_q + 32'd4;
              cnt_q <= cnt_q - LEN_W'(1);
              // cnt_q still holds the pre-decrement count here
              if (cnt_q == LEN_W'(1)) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                HADDR  <= src_q + 32'd4;
                HTRANS <= HTRANS_NONSEQ;
                HWRITE <= 1'b0;
                state  <= S_RD_A;
              end
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          busy   <= 1'b0;
          HTRANS <= HTRANS_IDLE;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_copy_master.sv
// Testbench for ahb_copy_master: an AHB-lite slave model with a scoreboard of
// expected read addresses and expected (address, data) writes, plus one task
// per scenario.
module tb_ahb_copy_master;

  localparam int unsigned LEN_W = 16;

  logic             HCLK = 1'b0;
  logic             HRESET = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, err;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [31:0]      HWDATA;
  logic [31:0]      HRDATA = '0;
  logic             HREADY = 1'b1;
  logic             HRESP = 1'b0;

  ahb_copy_master #(.LEN_W(LEN_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] exp_rd[$];
  logic [63:0] exp_wr[$];
  logic [31:0] rd_mem[logic [31:0]];
  logic [31:0] salt = '0;

  int unsigned cfg_waits = 0;
  int          cfg_err_rd = -1;
  int          rd_seen = 0;

  function automatic logic [31:0] rdval(input logic [31:0] a);
    if (rd_mem.exists(a)) return rd_mem[a];
    return a ^ 32'h3C5A_96F0 ^ salt;
  endfunction

  // Slave model: decisions at negedge (bus stable), drive after posedge.
  bit          dp_valid = 0;
  bit          dp_first = 0;
  logic [31:0] dp_addr = '0;
  logic [31:0] dp_wdata = '0;
  logic        dp_write = 1'b0;
  logic        dp_err = 1'b0;
  int unsigned dp_left = 0;

  initial begin
    logic [63:0] e;
    logic [31:0] ra;
    forever begin
      @(negedge HCLK);
      if (!HRESET) begin
        if (dp_valid) begin
          n_vec++;
          if (HTRANS !== 2'b00 || HADDR !== dp_addr || HWRITE !== dp_write) begin
            n_err++;
            $display("FAIL dphase_hold htrans=%b haddr=%h hwrite=%b exp htrans=00 haddr=%h hwrite=%b",
                     HTRANS, HADDR, HWRITE, dp_addr, dp_write);
          end
          if (dp_write) begin
            if (dp_first) dp_wdata = HWDATA;
            else begin
              n_vec++;
              if (HWDATA !== dp_wdata) begin
                n_err++;
                $display("FAIL hwdata_hold got=%h exp=%h", HWDATA, dp_wdata);
              end
            end
          end
          dp_first = 0;
          if (HREADY) begin
            if (dp_write && !dp_err) begin
              n_vec++;
              if (exp_wr.size() == 0) begin
                n_err++;
                $display("FAIL write_unexpected addr=%h data=%h exp=none", dp_addr, HWDATA);
              end else begin
                e = exp_wr.pop_front();
                if ({dp_addr, HWDATA} !== e) begin
                  n_err++;
                  $display("FAIL write addr=%h data=%h exp addr=%h data=%h",
                           dp_addr, HWDATA, e[63:32], e[31:0]);
                end
              end
            end
            dp_valid = 0;
          end else if (dp_left > 0) begin
            dp_left--;
          end
        end
        if (HTRANS == 2'b10 && HREADY) begin
          dp_valid = 1;
          dp_first = 1;
          dp_addr  = HADDR;
          dp_write = HWRITE;
          dp_err   = 1'b0;
          if (!HWRITE) begin
            n_vec++;
            if (exp_rd.size() == 0) begin
              n_err++;
              $display("FAIL read_unexpected addr=%h exp=none", HADDR);
            end else begin
              ra = exp_rd.pop_front();
              if (HADDR !== ra) begin
                n_err++;
                $display("FAIL read_addr got=%h exp=%h", HADDR, ra);
              end
            end
            dp_err = (rd_seen == cfg_err_rd);
            rd_seen++;
          end
          dp_left = dp_err ? 1 : cfg_waits;
        end
      end
      @(posedge HCLK);
      #1;
      if (HRESET) begin
        dp_valid = 0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
      end else if (dp_valid) begin
        HREADY = (dp_left == 0);
        HRESP  = dp_err;
        HRDATA = dp_write ? 32'h0 : rdval(dp_addr);
      end else begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
      end
    end
  end

  // Drives one copy command, pushes its expectations and observes done/busy.
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                          input int unsigned n, input int unsigned waits,
                          input int err_rd, input int poke_cyc,
                          output int done_cyc, output int npulse,
                          output bit busy_ok, output logic err_c1,
                          output logic err_end);
    logic [31:0] s, d, a;
    s = src & 32'hFFFF_FFFC;
    d = dst & 32'hFFFF_FFFC;
    cfg_waits  = waits;
    cfg_err_rd = err_rd;
    rd_seen    = 0;
    for (int i = 0; i < int'(n); i++) begin
      a = s + 32'(4 * i);
      exp_rd.push_back(a);
      if (i == err_rd) break;
      exp_wr.push_back({d + 32'(4 * i), rdval(a)});
    end
    @(negedge HCLK);
    start = 1'b1; src_addr = src; dst_addr = dst; len = LEN_W'(n);
    done_cyc = 0; npulse = 0; busy_ok = 1; err_c1 = 1'bx;
    for (int c = 1; c <= 400; c++) begin
      @(negedge HCLK);
      if (c == 1) begin
        start = 1'b0;
        err_c1 = err;
      end
      if (c == poke_cyc) begin
        start = 1'b1; src_addr = 32'h1234_5670; dst_addr = 32'h7654_3210; len = 7;
      end else if (c == poke_cyc + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        npulse++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (busy !== (done_cyc == 0)) busy_ok = 0;
      if (done_cyc != 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0;
    err_end = err;
  endtask

  task automatic test_reset;
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    n_vec++; if (HTRANS !== 2'b00) begin n_err++; $display("FAIL reset_htrans got=%b exp=00", HTRANS); end
    n_vec++; if (HADDR !== 32'h0) begin n_err++; $display("FAIL reset_haddr got=%h exp=0", HADDR); end
    n_vec++; if (HWRITE !== 1'b0) begin n_err++; $display("FAIL reset_hwrite got=%b exp=0", HWRITE); end
    n_vec++; if (HWDATA !== 32'h0) begin n_err++; $display("FAIL reset_hwdata got=%h exp=0", HWDATA); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err); end
    n_vec++; if (HSIZE !== 3'b010) begin n_err++; $display("FAIL hsize got=%b exp=010", HSIZE); end
    HRESET = 1'b0;
  endtask

  task automatic test_single;
    salt = $urandom;
    rd_mem[32'h2000_0000] = 32'hDEAD_BEEF;
    cfg_waits = 0; cfg_err_rd = -1; rd_seen = 0;
    exp_rd.push_back(32'h2000_0000);
    exp_wr.push_back({32'h2000_0100, 32'hDEAD_BEEF});
    @(negedge HCLK);
    start = 1'b1; src_addr = 32'h2000_0000; dst_addr = 32'h2000_0100; len = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge HCLK);
      if (c == 1) start = 1'b0;
      case (c)
        1: begin
          n_vec++;
          if (HTRANS !== 2'b10 || HADDR !== 32'h2000_0000 || HWRITE !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_c1 htrans=%b haddr=%h hwrite=%b busy=%b exp 10/20000000/0/1", HTRANS, HADDR, HWRITE, busy);
          end
        end
        2: begin
          n_vec++;
          if (HTRANS !== 2'b00) begin n_err++; $display("FAIL single_c2_htrans got=%b exp=00", HTRANS); end
        end
        3: begin
          n_vec++;
          if (HTRANS !== 2'b10 || HADDR !== 32'h2000_0100 || HWRITE !== 1'b1) begin
            n_err++;
            $display("FAIL single_c3 htrans=%b haddr=%h hwrite=%b exp 10/20000100/1", HTRANS, HADDR, HWRITE);
          end
        end
        4: begin
          n_vec++;
          if (HWDATA !== 32'hDEAD_BEEF || HTRANS !== 2'b00) begin
            n_err++;
            $display("FAIL single_c4 hwdata=%h htrans=%b exp deadbeef/00", HWDATA, HTRANS);
          end
        end
        5: begin
          n_vec++;
          if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_c5 done=%b busy=%b exp 1/0", done, busy);
          end
        end
        default: begin
          n_vec++;
          if (done !== 1'b0) begin n_err++; $display("FAIL single_c6_done got=%b exp=0", done); end
        end
      endcase
    end
    rd_mem.delete();
    n_vec++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      n_err++; $display("FAIL single_pending rd=%0d wr=%0d exp 0/0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_waits;
    int dc, np; bit bok; logic e1, ee;
    salt = $urandom;
    run_copy(32'h2000_0400, 32'h2000_0800, 4, 2, -1, 0, dc, np, bok, e1, ee);
    n_vec++; if (dc != 33) begin n_err++; $display("FAIL waits_done_cycle got=%0d exp=33", dc); end
    n_vec++; if (np != 1 || !bok) begin n_err++; $display("FAIL waits_pulse_busy pulses=%0d busy_ok=%0d exp 1/1", np, bok); end
    n_vec++; if (ee !== 1'b0) begin n_err++; $display("FAIL waits_err got=%b exp=0", ee); end
    n_vec++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      n_err++; $display("FAIL waits_pending rd=%0d wr=%0d exp 0/0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_error;
    int dc, np; bit bok; logic e1, ee;
    salt = $urandom;
    run_copy(32'h2000_1000, 32'h2000_2000, 3, 0, 1, 0, dc, np, bok, e1, ee);
    n_vec++; if (dc != 8) begin n_err++; $display("FAIL error_done_cycle got=%0d exp=8", dc); end
    n_vec++; if (np != 1 || !bok) begin n_err++; $display("FAIL error_pulse_busy pulses=%0d busy_ok=%0d exp 1/1", np, bok); end
    n_vec++; if (ee !== 1'b1) begin n_err++; $display("FAIL error_err got=%b exp=1", ee); end
    n_vec++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      n_err++; $display("FAIL error_pending rd=%0d wr=%0d exp 0/0", exp_rd.size(), exp_wr.size());
    end
    repeat (2) @(negedge HCLK);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL error_sticky got=%b exp=1", err); end
    cfg_err_rd = -1;
  endtask

  task automatic test_len_zero;
    @(negedge HCLK);
    start = 1'b1; src_addr = 32'h2000_0000; dst_addr = 32'h2000_0100; len = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge HCLK);
      if (c == 1) begin
        start = 1'b0;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL zero_err_clear got=%b exp=0", err); end
      end
      n_vec++;
      if (done !== (c == 1) || busy !== 1'b0 || HTRANS !== 2'b00) begin
        n_err++;
        $display("FAIL zero_c%0d done=%b busy=%b htrans=%b exp %0d/0/00", c, done, busy, HTRANS, (c == 1));
      end
    end
  endtask

  task automatic test_wrap;
    int dc, np; bit bok; logic e1, ee;
    salt = $urandom;
    run_copy(32'hFFFF_FFFC, 32'h0000_1000, 2, 0, -1, 0, dc, np, bok, e1, ee);
    n_vec++; if (dc != 9 || np != 1 || !bok) begin n_err++; $display("FAIL wrap_done cycle=%0d pulses=%0d busy_ok=%0d exp 9/1/1", dc, np, bok); end
    run_copy(32'h2000_0003, 32'h2000_0202, 1, 0, -1, 0, dc, np, bok, e1, ee);
    n_vec++; if (dc != 5 || np != 1 || !bok) begin n_err++; $display("FAIL unaligned_done cycle=%0d pulses=%0d busy_ok=%0d exp 5/1/1", dc, np, bok); end
    n_vec++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      n_err++; $display("FAIL wrap_pending rd=%0d wr=%0d exp 0/0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_start_busy;
    int dc, np; bit bok; logic e1, ee;
    salt = $urandom;
    run_copy(32'h3000_0000, 32'h3000_0100, 3, 0, -1, 6, dc, np, bok, e1, ee);
    n_vec++; if (dc != 13 || np != 1 || !bok) begin n_err++; $display("FAIL busy_start cycle=%0d pulses=%0d busy_ok=%0d exp 13/1/1", dc, np, bok); end
    run_copy(32'h3000_0200, 32'h3000_0300, 3, 0, -1, 13, dc, np, bok, e1, ee);
    n_vec++; if (dc != 13 || np != 1 || !bok) begin n_err++; $display("FAIL done_start cycle=%0d pulses=%0d busy_ok=%0d exp 13/1/1", dc, np, bok); end
    n_vec++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      n_err++; $display("FAIL start_busy_pending rd=%0d wr=%0d exp 0/0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_reset_mid;
    bit found;
    int pulses;
    salt = $urandom;
    cfg_waits = 0; cfg_err_rd = -1; rd_seen = 0;
    for (int i = 0; i < 2; i++) begin
      exp_rd.push_back(32'h2000_3000 + 32'(4 * i));
      exp_wr.push_back({32'h2000_3100 + 32'(4 * i), rdval(32'h2000_3000 + 32'(4 * i))});
    end
    @(negedge HCLK);
    start = 1'b1; src_addr = 32'h2000_3000; dst_addr = 32'h2000_3100; len = 2;
    found = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge HCLK);
      if (c == 1) start = 1'b0;
      if (HTRANS == 2'b10 && HWRITE == 1'b1) begin
        found = 1;
        HRESET = 1'b1;
      end
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rstmid_wr_a_seen got=0 exp=1"); end
    @(negedge HCLK);
    HRESET = 1'b0;
    n_vec++;
    if (HTRANS !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || HADDR !== 32'h0 || HWDATA !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_out htrans=%b busy=%b done=%b haddr=%h hwdata=%h exp 00/0/0/0/0", HTRANS, busy, done, HADDR, HWDATA);
    end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge HCLK);
      if (done !== 1'b0 || HTRANS !== 2'b00) pulses++;
    end
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL rstmid_quiet bad_cycles=%0d exp=0", pulses); end
    n_vec++;
    if (exp_rd.size() != 1 || exp_wr.size() != 2) begin
      n_err++; $display("FAIL rstmid_pending rd=%0d wr=%0d exp 1/2", exp_rd.size(), exp_wr.size());
    end
    exp_rd.delete();
    exp_wr.delete();
  endtask

  task automatic test_back_to_back;
    int dc, np; bit bok; logic e1, ee;
    salt = $urandom;
    run_copy(32'h2000_4000, 32'h2000_5000, 2, 1, -1, 0, dc, np, bok, e1, ee);
    n_vec++; if (dc != 13 || np != 1 || !bok) begin n_err++; $display("FAIL b2b_first cycle=%0d pulses=%0d busy_ok=%0d exp 13/1/1", dc, np, bok); end
    run_copy(32'h2000_6000, 32'h2000_7000, 3, 0, -1, 0, dc, np, bok, e1, ee);
    n_vec++; if (dc != 13 || np != 1 || !bok) begin n_err++; $display("FAIL b2b_second cycle=%0d pulses=%0d busy_ok=%0d exp 13/1/1", dc, np, bok); end
    n_vec++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      n_err++; $display("FAIL b2b_pending rd=%0d wr=%0d exp 0/0", exp_rd.size(), exp_wr.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_single;
    test_waits;
    test_error;
    test_len_zero;
    test_wrap;
    test_start_busy;
    test_reset_mid;
    test_back_to_back;
    repeat (2) @(negedge HCLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
